// File: rtl/scan_pkg.sv
// Shared constants for the scan decoder: default geometry, mode encodings, FSM states.
package scan_pkg;

  localparam int N_DEF      = 150;
  localparam int ADDR_W_DEF = 15;
  localparam int CW         = 8;

  localparam logic [1:0] MODE_LR  = 2'b00;
  localparam logic [1:0] MODE_UD  = 2'b01;
  localparam logic [1:0] MODE_TTL = 2'b10;
  localparam logic [1:0] MODE_TTR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } pos_t;

  // Every mode starts at row 0; only TTR starts in the rightmost column.
  function automatic pos_t first_pos(input logic [1:0] mode, input logic [CW-1:0] last);
    pos_t p;
    p.row = '0;
    p.col = (mode == MODE_TTR) ? last : '0;
    return p;
  endfunction

endpackage

// File: rtl/scan_step.sv
// Combinational next-position calculator for the four scan orders.
// Also flags whether the current position ends its scan line and/or the frame.
module scan_step
  import scan_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [1:0]    mode,
  input  logic [CW-1:0] cur_row,
  input  logic [CW-1:0] cur_col,
  output logic [CW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output logic          line_end,
  output logic          frame_end
);

  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW:0]   NM1    = (CW + 1)'(N - 1);
  localparam logic [CW:0]   TWO_N3 = (CW + 1)'(2 * N - 3);
  localparam logic [CW:0]   ONE_W  = (CW + 1)'(1);

  // Diagonal index d of the current position for each diagonal order.
  logic [CW:0] diag_l;
  logic [CW:0] diag_r;

  assign diag_l = {1'b0, cur_row} + {1'b0, cur_col};
  assign diag_r = {1'b0, cur_row} + {1'b0, LAST - cur_col};

  always_comb begin
    nxt_row   = cur_row;
    nxt_col   = cur_col;
    line_end  = 1'b0;
    frame_end = 1'b0;
    case (mode)
      MODE_LR: begin
        line_end  = (cur_col == LAST);
        frame_end = line_end && (cur_row == LAST);
        if (line_end) begin
          nxt_col = '0;
          nxt_row = cur_row + CW'(1);
        end else begin
          nxt_col = cur_col + CW'(1);
        end
      end
      MODE_UD: begin
        line_end  = (cur_row == LAST);
        frame_end = line_end && (cur_col == LAST);
        if (line_end) begin
          nxt_row = '0;
          nxt_col = cur_col + CW'(1);
        end else begin
          nxt_row = cur_row + CW'(1);
        end
      end
      MODE_TTL: begin
        line_end  = (cur_row == '0) || (cur_col == LAST);
        frame_end = (cur_row == LAST) && (cur_col == LAST);
        if (!line_end) begin
          nxt_row = cur_row - CW'(1);
          nxt_col = cur_col + CW'(1);
        end else if (diag_l < NM1) begin
          nxt_row = CW'(diag_l + ONE_W);
          nxt_col = '0;
        end else begin
          nxt_row = LAST;
          nxt_col = CW'(diag_l - NM1 + ONE_W);
        end
      end
      default: begin
        line_end  = (cur_row == '0) || (cur_col == '0);
        frame_end = (cur_row == LAST) && (cur_col == '0);
        if (!line_end) begin
          nxt_row = cur_row - CW'(1);
          nxt_col = cur_col - CW'(1);
        end else if (diag_r < NM1) begin
          nxt_row = CW'(diag_r + ONE_W);
          nxt_col = LAST;
        end else begin
          nxt_row = LAST;
          nxt_col = CW'(TWO_N3 - diag_r);
        end
      end
    endcase
  end

endmodule

// File: rtl/scan_decoder.sv
// Scan-order decoder: turns a stream of linear pixel indices into (row, col) plus line/frame markers.
// Optional SCAN_CHECK_EN: compares in_addr with the expected index and raises a sticky err.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting beats of a frame
//   DONE  | last beat of the frame accepted, waiting for start
module scan_decoder
  import scan_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic              line_end,
  output logic              frame_end,
  output logic              err
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [CW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic [CW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;
  logic          step_le;
  logic          step_fe;
  logic          accept;
  pos_t          start_pos;

  assign start_pos = first_pos(mode, LAST);
  assign in_ready  = (state == ST_RUN) && !start && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  scan_step #(.N(N)) u_step (
    .mode      (mode_q),
    .cur_row   (cur_row),
    .cur_col   (cur_col),
    .nxt_row   (nxt_row),
    .nxt_col   (nxt_col),
    .line_end  (step_le),
    .frame_end (step_fe)
  );

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_LR;
      cur_row   <= '0;
      cur_col   <= '0;
      out_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else if (start) begin
      state     <= ST_RUN;
      mode_q    <= mode;
      cur_row   <= start_pos.row;
      cur_col   <= start_pos.col;
      out_valid <= 1'b0;
    end else if (accept) begin
      row       <= cur_row;
      col       <= cur_col;
      line_end  <= step_le;
      frame_end <= step_fe;
      out_valid <= 1'b1;
      cur_row   <= nxt_row;
      cur_col   <= nxt_col;
      if (step_fe) state <= ST_DONE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SCAN_CHECK_EN
  logic [ADDR_W-1:0] exp_addr;
  logic              err_q;

  assign exp_addr = ADDR_W'(cur_row) * ADDR_W'(N) + ADDR_W'(cur_col);

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (accept && (in_addr != exp_addr)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^in_addr;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder with N=150: scan orders, backpressure, start/reset behaviour.
module tb_scan_decoder;

  localparam int N = 150;

`ifdef SCAN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        line_end;
  logic        frame_end;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  scan_decoder #(.N(N), .ADDR_W(15)) dut (
    .clk       (clk),
    .resetIn   (resetIn),
    .mode      (mode),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row       (row),
    .col       (col),
    .line_end  (line_end),
    .frame_end (frame_end),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted, in_valid still high.
  task automatic beat(input logic [14:0] a);
    int g;
    in_valid = 1'b1;
    in_addr  = a;
    #1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] m);
    in_valid = 1'b0;
    start    = 1'b1;
    mode     = m;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic chk_pos(input string tag, input int r, input int c, input logic le, input logic fe);
    chk({tag, "_row"}, row, r);
    chk({tag, "_col"}, col, c);
    chk({tag, "_le"}, line_end, le);
    chk({tag, "_fe"}, frame_end, fe);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    chk("rst_err", err, 0);
    chk_pos("rst", 0, 0, 0, 0);
    resetIn = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_ir", in_ready, 0);

    // LR full frame
    do_start(2'b00);
    chk("lr_start_ov", out_valid, 0);
    bad = 0;
    for (int i = 0; i < N * N; i++) begin
      beat(15'(i));
      if (row != 8'(i / N) || col != 8'(i % N) || line_end != ((i % N) == N - 1) ||
          frame_end != (i == N * N - 1) || out_valid != 1'b1)
        bad++;
      if (i == 0) chk_pos("lr_b1", 0, 0, 0, 0);
      if (i == 149) chk_pos("lr_b150", 0, 149, 1, 0);
      if (i == N * N - 1) chk_pos("lr_last", 149, 149, 1, 1);
    end
    chk("lr_all", bad, 0);
    chk("lr_err", err, 0);
    #1;
    chk("lr_done_ir", in_ready, 0);

    // UD
    do_start(2'b01);
    beat(0);   chk_pos("ud_b1", 0, 0, 0, 0);
    beat(150); chk_pos("ud_b2", 1, 0, 0, 0);
    beat(300); chk_pos("ud_b3", 2, 0, 0, 0);
    for (int i = 3; i < N; i++) beat(15'(i * N));
    chk_pos("ud_b150", 149, 0, 1, 0);
    beat(1);   chk_pos("ud_b151", 0, 1, 0, 0);
    chk("ud_err", err, 0);

    // TTL
    do_start(2'b10);
    beat(0);   chk_pos("ttl_b1", 0, 0, 1, 0);
    beat(150); chk_pos("ttl_b2", 1, 0, 0, 0);
    beat(1);   chk_pos("ttl_b3", 0, 1, 1, 0);
    beat(300); chk_pos("ttl_b4", 2, 0, 0, 0);
    chk("ttl_err", err, 0);

    // TTR
    do_start(2'b11);
    beat(149); chk_pos("ttr_b1", 0, 149, 1, 0);
    beat(299); chk_pos("ttr_b2", 1, 149, 0, 0);
    beat(148); chk_pos("ttr_b3", 0, 148, 1, 0);
    chk("ttr_err", err, 0);

    // Address check: wrong second beat in UD
    do_start(2'b01);
    beat(0);
    chk("chk_err0", err, 0);
    beat(151);
    chk("chk_err_rise", err, EXP_ERR);
    chk("chk_pos_follow", row, 1);
    beat(300);
    chk("chk_err_sticky", err, EXP_ERR);
    do_start(2'b01);
    chk("chk_err_clr", err, 0);

    // Start wins over a simultaneous beat
    do_start(2'b00);
    beat(0);
    start = 1'b1; in_valid = 1'b1; in_addr = 15'd1; mode = 2'b00;
    #1;
    chk("sw_ir", in_ready, 0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("sw_ov", out_valid, 0);
    beat(0); chk_pos("sw_b1", 0, 0, 0, 0);

    // Backpressure mid-line
    beat(1); chk("bp_pre_col", col, 1);
    out_ready = 1'b0;
    in_addr   = 15'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ir", in_ready, 0);
      chk("bp_ov", out_valid, 1);
      chk("bp_col", col, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    beat(2); chk("bp_col2", col, 2); chk("bp_ov2", out_valid, 1);
    beat(3); chk("bp_col3", col, 3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_ov", out_valid, 0);

    // Reset mid-frame at beat 500
    do_start(2'b00);
    for (int i = 0; i < 500; i++) beat(15'(i));
    chk_pos("mr_b500", 3, 49, 0, 0);
    in_valid = 1'b0;
    resetIn  = 1'b0;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_ir", in_ready, 0);
    chk_pos("mr", 0, 0, 0, 0);
    @(negedge clk);
    resetIn = 1'b1;
    in_valid = 1'b1;
    in_addr  = 15'd500;
    #1;
    chk("mr_idle_ir", in_ready, 0);
    @(negedge clk);
    do_start(2'b00);
    beat(0);
    chk_pos("mr_replay", 0, 0, 0, 0);
    chk("mr_replay_ov", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
